norm_unit: RTL

- Iterative normalizer for the datapath: the inverse of the one-bit shift stage.
- Accepts a 16-bit operand and left-shifts it one bit per cycle until it is normalized.
- Returns the normalized value and the number of shifts applied, so software or the controller can recover the shift amount.
- Sits beside the ALU/shift stage and is driven by the controller FSM through a start/done handshake.

---
 rtl/norm_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/norm_unit.sv
// Iterative left-shift normalizer with start/done handshake; returns shifted value and shift count.
// Define NORM_SIGNED_EN to add the mode port and signed (sign-bit != next bit) normalization.
module norm_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] in,
`ifdef NORM_SIGNED_EN
  input  logic        mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] sout,
  output logic [3:0]  count,
  output logic        zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state_r;
  logic [15:0] w_r;
  logic [3:0]  n_r;
  logic        m_r;
  logic        mode_s;
  logic        wzero_s;
  logic        norm_s;

`ifdef NORM_SIGNED_EN
  assign mode_s = mode;
`else
  assign mode_s = 1'b0;
`endif

  // Termination test for the current work value
  always_comb begin
    wzero_s = (w_r == 16'h0000);
    if (m_r) begin
      norm_s = (w_r[15] != w_r[14]);
    end else begin
      norm_s = w_r[15];
    end
  end

  // Controller FSM, work registers and registered result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      w_r     <= 16'h0000;
      n_r     <= 4'd0;
      m_r     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sout    <= 16'h0000;
      count   <= 4'd0;
      zero    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            w_r     <= in;
            m_r     <= mode_s;
            n_r     <= 4'd0;
            busy    <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          busy <= 1'b1;
          // Zero and already-normalized both finish; zero takes priority for the flag
          if (wzero_s || norm_s) begin
            sout    <= w_r;
            count   <= n_r;
            zero    <= wzero_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            w_r     <= {w_r[14:0], 1'b0};
            n_r     <= n_r + 4'd1;
            done    <= 1'b0;
            state_r <= SHIFT;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
